// File: rtl/debounce_event_ctrl.sv
`timescale 1ns/1ps
// debounce_event_ctrl
//   Multi-channel switch debouncer with a shared tick generator and a
//   round-robin arbiter. The arbiter serialises press/release events onto a
//   single valid/ready port.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   sw         : raw switch levels [NUM_SW]
//   db         : debounced levels [NUM_SW]
//   tick_out   : registered one-cycle tick pulse, every TICK_DIV cycles
//   evt_valid  : event offered
//   evt_ready  : consumer accepts event
//   evt_id     : channel index of the offered event [ID_W]
//   evt_press  : 1 = press (rising), 0 = release (falling)
//   overrun    : one-cycle pulse when an unserviced event is overwritten
//
// Build option
//   SW_SYNC_EN : when defined, every sw bit passes through a 2-flop
//                synchroniser before the filter.
module debounce_event_ctrl #(
  parameter int NUM_SW       = 4,
  parameter int ID_W         = 2,
  parameter int TICK_DIV     = 500000,
  parameter int CNT_N        = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] db,
  output logic              tick_out,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic              evt_press,
  output logic              overrun
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_N-1:0]  r_tick_cnt;
  logic              w_tick;
  logic [NUM_SW-1:0] w_s;
  logic [2:0]        r_flt_cnt [NUM_SW];
  logic [NUM_SW-1:0] r_db, r_pending, r_pend_dir;
  logic [NUM_SW-1:0] w_edge, w_pick, w_clr;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_nxt, w_sel;
  logic              w_sel_vld, w_capture, w_handshake;
  logic              r_tick_out, r_evt_valid, r_evt_press, r_overrun;
  logic [ID_W-1:0]   r_evt_id;

  // Shared tick generator
  assign w_tick = (r_tick_cnt == CNT_N'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_tick_cnt <= '0;
    else               r_tick_cnt <= r_tick_cnt + CNT_N'(1);
  end

`ifdef SW_SYNC_EN
  logic [NUM_SW-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = sw;
`endif

  // A channel flips on the tick that completes STABLE_TICKS of disagreement
  always_comb begin
    w_edge = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      w_edge[i] = (w_s[i] != r_db[i]) && w_tick &&
                  (r_flt_cnt[i] == 3'(STABLE_TICKS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db <= '0;
      for (int unsigned i = 0; i < NUM_SW; i++) r_flt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        if (w_s[i] == r_db[i]) begin
          r_flt_cnt[i] <= '0;
        end else if (w_tick) begin
          if (w_edge[i]) begin
            r_flt_cnt[i] <= '0;
            r_db[i]      <= ~r_db[i];
          end else begin
            r_flt_cnt[i] <= r_flt_cnt[i] + 3'd1;
          end
        end
      end
    end
  end

  // Round-robin pick: first pass scans [rr_ptr, NUM_SW), second pass wraps
  // to the lowest pending index overall. Equivalent to a modulo scan.
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    w_pick    = '0;
    for (int unsigned j = 0; j < NUM_SW; j++) begin
      if (!w_sel_vld && r_pending[j] && (j >= 32'(r_rr_ptr))) begin
        w_sel     = ID_W'(j);
        w_sel_vld = 1'b1;
        w_pick[j] = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_SW; j++) begin
      if (!w_sel_vld && r_pending[j]) begin
        w_sel     = ID_W'(j);
        w_sel_vld = 1'b1;
        w_pick[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt = OFFER;
          w_capture   = 1'b1;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          w_state_nxt = IDLE;
          w_handshake = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_clr    = w_capture ? w_pick : '0;
  assign w_rr_nxt = (32'(r_evt_id) == 32'(NUM_SW - 1)) ? '0 : r_evt_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_pending   <= '0;
      r_pend_dir  <= '0;
      r_evt_id    <= '0;
      r_evt_press <= 1'b0;
      r_evt_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_tick_out  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_evt_valid <= (w_state_nxt == OFFER);
      r_tick_out  <= w_tick;
      if (w_capture) begin
        r_evt_id    <= w_sel;
        r_evt_press <= |(w_pick & r_pend_dir);
      end
      if (w_handshake) r_rr_ptr <= w_rr_nxt;
      // A new edge on the channel being captured re-arms pending and is not
      // an overrun: the captured event was already taken.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_overrun <= |(w_edge & r_pending & ~w_clr);
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        if (w_edge[i]) r_pend_dir[i] <= ~r_db[i];
      end
    end
  end

  assign db        = r_db;
  assign tick_out  = r_tick_out;
  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_press = r_evt_press;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_debounce_event_ctrl.sv
`timescale 1ns/1ps
module tb_debounce_event_ctrl;

  localparam int NSW   = 4;
  localparam int IDW   = 2;
  localparam int TDIV  = 4;
  localparam int STBL  = 3;
`ifdef SW_SYNC_EN
  localparam int LAT_MIN = 11;
  localparam int LAT_MAX = 14;
`else
  localparam int LAT_MIN = 9;
  localparam int LAT_MAX = 12;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NSW-1:0] sw = '0;
  logic [NSW-1:0] db;
  logic           tick_out, evt_valid, evt_press, overrun;
  logic           evt_ready = 1'b0;
  logic [IDW-1:0] evt_id;

  debounce_event_ctrl #(
    .NUM_SW(NSW), .ID_W(IDW), .TICK_DIV(TDIV), .CNT_N(3), .STABLE_TICKS(STBL)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .db(db), .tick_out(tick_out),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_press(evt_press), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: tick phase from cycles since reset, filter as a count
  // of ticks seen during the current disagreement run, arbiter as a
  // rotating scan over a pending array.
  int             m_cyc = 0;
  logic [NSW-1:0] m_db = '0, m_pend = '0, m_dir = '0, m_sy1 = '0, m_sy2 = '0;
  int             m_run [NSW];
  logic           m_offer = 1'b0, m_press = 1'b0, m_ovr = 1'b0, m_tick_out = 1'b0;
  int             m_id = 0, m_rr = 0;
  logic [NSW-1:0] m_s, m_edge, m_clr, m_oldp;
  logic           m_tk;
  int             m_pick;

  always @(posedge clk) begin
`ifdef SW_SYNC_EN
    m_s   = m_sy2;
    m_sy2 = m_sy1;
    m_sy1 = sw;
`else
    m_s = sw;
`endif
    if (rst) begin
      m_cyc = 0; m_db = '0; m_pend = '0; m_dir = '0; m_offer = 0;
      m_press = 0; m_ovr = 0; m_tick_out = 0; m_id = 0; m_rr = 0;
      m_sy1 = '0; m_sy2 = '0;
      for (int i = 0; i < NSW; i++) m_run[i] = 0;
    end else begin
      m_tk = ((m_cyc % TDIV) == TDIV - 1);
      m_cyc++;
      m_tick_out = m_tk;
      m_edge = '0;
      for (int i = 0; i < NSW; i++) begin
        if (m_s[i] == m_db[i]) m_run[i] = 0;
        else if (m_tk) begin
          m_run[i]++;
          if (m_run[i] == STBL) begin
            m_run[i] = 0; m_db[i] = ~m_db[i]; m_edge[i] = 1'b1;
          end
        end
      end
      m_oldp = m_pend;
      m_clr  = '0;
      if (m_offer) begin
        if (evt_ready) begin m_offer = 0; m_rr = (m_id + 1) % NSW; end
      end else if (m_oldp != '0) begin
        m_pick = -1;
        for (int k = 0; k < NSW; k++)
          if (m_pick < 0 && m_oldp[(m_rr + k) % NSW]) m_pick = (m_rr + k) % NSW;
        m_clr[m_pick] = 1'b1;
        m_id = m_pick; m_press = m_dir[m_pick]; m_offer = 1;
      end
      m_ovr  = |(m_edge & m_oldp & ~m_clr);
      m_pend = (m_oldp & ~m_clr) | m_edge;
      for (int i = 0; i < NSW; i++) if (m_edge[i]) m_dir[i] = m_db[i];
    end
  end

  typedef struct { int cyc; int id; int press; } ev_t;
  ev_t obs_q[$];
  int  cyc = 0;
  int  ovr_cnt = 0;
  bit  chk_en = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (chk_en) begin
    check("db", db, m_db);
    check("tick_out", tick_out, m_tick_out);
    check("evt_valid", evt_valid, m_offer);
    if (m_offer) begin
      check("evt_id", evt_id, m_id);
      check("evt_press", evt_press, m_press);
    end
    check("overrun", overrun, m_ovr);
    if (overrun === 1'b1) ovr_cnt++;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) obs_q.push_back('{cyc, int'(evt_id), int'(evt_press)});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_db(input int ch, input logic v, input int budget, output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (db[ch] !== v && lat < budget);
    if (db[ch] !== v) check("wait_db_timeout", db[ch], v);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    @(negedge clk);
    while (evt_valid !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (evt_valid !== 1'b1) check("wait_valid_timeout", evt_valid, 1);
  endtask

  task automatic expect_seq(input string tag, input int first_id, input int press, input int n);
    check({tag, "_count"}, obs_q.size(), n);
    for (int k = 0; k < n && k < obs_q.size(); k++) begin
      check({tag, "_id"}, obs_q[k].id, (first_id + k) % NSW);
      check({tag, "_press"}, obs_q[k].press, press);
      if (k > 0) check({tag, "_spacing"}, obs_q[k].cyc - obs_q[k-1].cyc, 2);
    end
    obs_q.delete();
  endtask

  int lat;

  initial begin
    // 1: reset and single press
    step(1);
    chk_en = 1;
    step(1);
    rst = 0;
    @(negedge clk);
    check("rst_db", db, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_press", evt_press, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tick", tick_out, 0);
    @(posedge clk); #1;
    sw = 4'b0001; evt_ready = 1;
    wait_db(0, 1'b1, 40, lat);
    check("s1_latency_in_range", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    step(6);
    expect_seq("s1_press", 0, 1, 1);
    sw = 4'b0000;
    wait_db(0, 1'b0, 40, lat);
    step(6);
    expect_seq("s1_release", 0, 0, 1);

    // 2: bounce rejection on ch1
    repeat (3) begin
      sw = 4'b0010; step(6);
      sw = 4'b0000; step(6);
    end
    check("s2_db", db, 0);
    check("s2_events", obs_q.size(), 0);
    obs_q.delete();

    // 3: simultaneous presses from rr_ptr = 0, then releases
    rst = 1; step(2); rst = 0;
    sw = 4'b1111; evt_ready = 1;
    wait_db(0, 1'b1, 40, lat);
    step(12);
    expect_seq("s3_press", 0, 1, 4);
    sw = 4'b0000;
    wait_db(0, 1'b0, 40, lat);
    step(12);
    expect_seq("s3_release", 0, 0, 4);

    // 4: backpressure and overrun
    ovr_cnt = 0;
    evt_ready = 0; step(1);
    sw = 4'b0100;
    wait_valid(40);
    check("s4_id_first", evt_id, 2);
    step(1);
    sw = 4'b1100;
    wait_db(3, 1'b1, 40, lat);
    step(1);
    sw = 4'b0100;
    wait_db(3, 1'b0, 40, lat);
    step(3);
    check("s4_id_held", evt_id, 2);
    check("s4_valid_held", evt_valid, 1);
    check("s4_overrun_once", ovr_cnt, 1);
    evt_ready = 1;
    step(8);
    check("s4_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("s4_ev0_id", obs_q[0].id, 2);
      check("s4_ev0_press", obs_q[0].press, 1);
      check("s4_ev1_id", obs_q[1].id, 3);
      check("s4_ev1_press", obs_q[1].press, 0);
    end
    obs_q.delete();

    // 5: reset while an event is offered
    evt_ready = 0;
    sw = 4'b0000;
    wait_valid(40);
    step(1);
    rst = 1;
    @(posedge clk); @(negedge clk);
    check("s5_valid_after_rst", evt_valid, 0);
    check("s5_db_after_rst", db, 0);
    step(1);
    rst = 0; evt_ready = 1;
    step(30);
    check("s5_no_events", obs_q.size(), 0);
    obs_q.delete();

    // Randomized phase: model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      int ch;
      step(1);
      if ($urandom_range(7) == 0) begin
        ch = $urandom_range(NSW - 1);
        sw[ch] = ~sw[ch];
      end
      evt_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(999) == 0);
    end
    rst = 0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
